// File: rtl/jump_ctrl_if.sv
// Decoder/PC-side signal bundle for jump_ctrl: op decode inputs, LUT write port,
// jump redirect outputs and RAS status.
interface jump_ctrl_if #(
  parameter int D  = 10,
  parameter int LW = 5
);
  logic [D-1:0]  prog_ctr;
  logic [1:0]    op;
  logic [LW-1:0] lut_idx;
  logic          zero_flag;
  logic          lut_we;
  logic [LW-1:0] lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic          jb_en;
  logic [D-1:0]  target;
  logic          ras_empty;
  logic          ras_full;
  logic          fault;

  modport master (
    output prog_ctr, op, lut_idx, zero_flag, lut_we, lut_waddr, lut_wdata,
    input  jb_en, target, ras_empty, ras_full, fault
  );

  modport slave (
    input  prog_ctr, op, lut_idx, zero_flag, lut_we, lut_waddr, lut_wdata,
    output jb_en, target, ras_empty, ras_full, fault
  );
endinterface

// File: rtl/jump_ctrl.sv
// Jump/branch/call/return engine: absolute-target LUT, return-address stack and
// sticky over/underflow fault. Redirect outputs are combinational for same-edge PC update.
module jump_ctrl #(
  parameter int D  = 10,
  parameter int LW = 5,
  parameter int SD = 4
) (
  input logic        clk,
  input logic        reset,
  jump_ctrl_if.slave jc
);
  localparam int PW = $clog2(SD) + 1;
  localparam int LN = 1 << LW;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BRZ  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  logic [D-1:0]  lut_q [LN];
  logic [D-1:0]  lut_d [LN];
  logic [D-1:0]  ras_q [SD];
  logic [D-1:0]  ras_d [SD];
  logic [PW-1:0] ptr_q, ptr_d;
  logic          fault_q, fault_d;

  logic          empty, full;
  logic [PW-2:0] wr_slot, top_slot;
  logic [D-1:0]  lut_rd;
  logic          jb_en;
  logic [D-1:0]  target;

  assign empty    = (ptr_q == '0);
  assign full     = (ptr_q == PW'(SD));
  // SD is a power of two, so the low pointer bits wrap cleanly: at ptr=SD the top is slot SD-1.
  assign wr_slot  = ptr_q[PW-2:0];
  assign top_slot = ptr_q[PW-2:0] - 1'b1;
  assign lut_rd   = lut_q[jc.lut_idx];

  always_comb begin
    jb_en   = 1'b0;
    target  = '0;
    lut_d   = lut_q;
    ras_d   = ras_q;
    ptr_d   = ptr_q;
    fault_d = fault_q;
    case (jc.op)
      OP_BRZ: begin
        if (jc.zero_flag) begin
          jb_en  = 1'b1;
          target = lut_rd;
        end
      end
      OP_CALL: begin
        if (!full) begin
          jb_en          = 1'b1;
          target         = lut_rd;
          ras_d[wr_slot] = jc.prog_ctr + D'(1);
          ptr_d          = ptr_q + PW'(1);
        end else begin
          fault_d = 1'b1;
        end
      end
      OP_RET: begin
        if (!empty) begin
          jb_en  = 1'b1;
          target = ras_q[top_slot];
          ptr_d  = ptr_q - PW'(1);
        end else begin
          fault_d = 1'b1;
        end
      end
      default: ;
    endcase
    // Applied after the read path above so same-cycle reads see the old entry.
    if (jc.lut_we) lut_d[jc.lut_waddr] = jc.lut_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LN; i++) lut_q[i] <= '0;
      ptr_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      lut_q   <= lut_d;
      ptr_q   <= ptr_d;
      fault_q <= fault_d;
    end
  end

  // Stack contents above the pointer are don't-care, so the array needs no reset.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign jc.jb_en     = jb_en;
  assign jc.target    = target;
  assign jc.ras_empty = empty;
  assign jc.ras_full  = full;
  assign jc.fault     = fault_q;
endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: redirect expectations are queued when ops are
// driven and popped when the combinational outputs are sampled on the falling edge.
module tb_jump_ctrl;
  logic clk = 1'b0;
  logic reset;

  jump_ctrl_if #(.D(10), .LW(5)) jc ();

  jump_ctrl #(.D(10), .LW(5), .SD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .jc    (jc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       jb;
    logic [9:0] tg;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic drive(input logic [1:0] op, input logic [4:0] idx, input logic zf,
                       input logic [9:0] pc, input logic we, input logic [4:0] wa,
                       input logic [9:0] wd);
    jc.op        = op;
    jc.lut_idx   = idx;
    jc.zero_flag = zf;
    jc.prog_ctr  = pc;
    jc.lut_we    = we;
    jc.lut_waddr = wa;
    jc.lut_wdata = wd;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(2'b00, 5'd0, 1'b0, 10'h000, 1'b0, 5'd0, 10'h000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, 10'h000, "idle"});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
        bad++;
        $display("FAIL %s cyc%0d: got jb_en=%b target=%h, want jb_en=%b target=%h",
                 e.nm, i, jc.jb_en, jc.target, e.jb, e.tg);
      end
      total++;
      if ({jc.ras_empty, jc.ras_full, jc.fault} !== 3'b100) begin
        bad++;
        $display("FAIL reset_status cyc%0d: got empty/full/fault=%b%b%b, want 100",
                 i, jc.ras_empty, jc.ras_full, jc.fault);
      end
      next_cyc();
    end
  endtask

  task automatic test_branch();
    drive(2'b00, 5'd0, 1'b0, 10'h000, 1'b1, 5'd3, 10'h155);
    next_cyc();
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 5'd3, (i == 0), 10'h020, 1'b0, 5'd0, 10'h000);
      if (i == 0) sb.push_back('{1'b1, 10'h155, "brz_taken"});
      else        sb.push_back('{1'b0, 10'h000, "brz_not_taken"});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
        bad++;
        $display("FAIL %s: got jb_en=%b target=%h, want jb_en=%b target=%h",
                 e.nm, jc.jb_en, jc.target, e.jb, e.tg);
      end
      next_cyc();
    end
  endtask

  // Also covers back-to-back call then return with no idle cycle between.
  task automatic test_call_ret();
    drive(2'b00, 5'd0, 1'b0, 10'h000, 1'b1, 5'd2, 10'h040);
    next_cyc();
    drive(2'b10, 5'd2, 1'b0, 10'h010, 1'b0, 5'd0, 10'h000);
    sb.push_back('{1'b1, 10'h040, "call"});
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
      bad++;
      $display("FAIL %s: got jb_en=%b target=%h, want jb_en=%b target=%h",
               e.nm, jc.jb_en, jc.target, e.jb, e.tg);
    end
    next_cyc();
    drive(2'b11, 5'd0, 1'b0, 10'h045, 1'b0, 5'd0, 10'h000);
    sb.push_back('{1'b1, 10'h011, "return"});
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
      bad++;
      $display("FAIL %s: got jb_en=%b target=%h, want jb_en=%b target=%h",
               e.nm, jc.jb_en, jc.target, e.jb, e.tg);
    end
    total++;
    if (jc.ras_empty !== 1'b0) begin
      bad++;
      $display("FAIL ras_one_entry: got ras_empty=%b, want 0", jc.ras_empty);
    end
    next_cyc();
    drive(2'b00, 5'd0, 1'b0, 10'h000, 1'b0, 5'd0, 10'h000);
    @(negedge clk);
    total++;
    if (jc.ras_empty !== 1'b1) begin
      bad++;
      $display("FAIL ras_empty_after_ret: got %b, want 1", jc.ras_empty);
    end
    next_cyc();
  endtask

  task automatic test_stack_limits();
    logic [9:0] ret_pc;
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 5'd2, 1'b0, 10'(i + 1), 1'b0, 5'd0, 10'h000);
      if (i < 4) sb.push_back('{1'b1, 10'h040, "fill_call"});
      else       sb.push_back('{1'b0, 10'h000, "overflow_call"});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
        bad++;
        $display("FAIL %s %0d: got jb_en=%b target=%h, want jb_en=%b target=%h",
                 e.nm, i, jc.jb_en, jc.target, e.jb, e.tg);
      end
      next_cyc();
    end
    drive(2'b00, 5'd0, 1'b0, 10'h000, 1'b0, 5'd0, 10'h000);
    @(negedge clk);
    total++;
    if ({jc.ras_full, jc.ras_empty, jc.fault} !== 3'b101) begin
      bad++;
      $display("FAIL overflow_status: got full/empty/fault=%b%b%b, want 101",
               jc.ras_full, jc.ras_empty, jc.fault);
    end
    next_cyc();
    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 5'd0, 1'b0, 10'h100, 1'b0, 5'd0, 10'h000);
      ret_pc = 10'(5 - i);
      if (i < 4) sb.push_back('{1'b1, ret_pc, "drain_ret"});
      else       sb.push_back('{1'b0, 10'h000, "underflow_ret"});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
        bad++;
        $display("FAIL %s %0d: got jb_en=%b target=%h, want jb_en=%b target=%h",
                 e.nm, i, jc.jb_en, jc.target, e.jb, e.tg);
      end
      next_cyc();
    end
    drive(2'b00, 5'd0, 1'b0, 10'h000, 1'b0, 5'd0, 10'h000);
    @(negedge clk);
    total++;
    if ({jc.ras_full, jc.ras_empty, jc.fault} !== 3'b011) begin
      bad++;
      $display("FAIL underflow_status: got full/empty/fault=%b%b%b, want 011",
               jc.ras_full, jc.ras_empty, jc.fault);
    end
    next_cyc();
  endtask

  task automatic test_read_before_write();
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 5'd7, 1'b1, 10'h030, (i == 0), 5'd7, 10'h2AA);
      if (i == 0) sb.push_back('{1'b1, 10'h000, "rbw_old"});
      else        sb.push_back('{1'b1, 10'h2AA, "rbw_new"});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
        bad++;
        $display("FAIL %s: got jb_en=%b target=%h, want jb_en=%b target=%h",
                 e.nm, jc.jb_en, jc.target, e.jb, e.tg);
      end
      next_cyc();
    end
  endtask

  task automatic test_wrap_and_reset();
    // Call from the last address, return (wrapped 0), then two pushes left on the stack.
    drive(2'b10, 5'd2, 1'b0, 10'h3FF, 1'b0, 5'd0, 10'h000);
    sb.push_back('{1'b1, 10'h040, "wrap_call"});
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
      bad++;
      $display("FAIL %s: got jb_en=%b target=%h, want jb_en=%b target=%h",
               e.nm, jc.jb_en, jc.target, e.jb, e.tg);
    end
    next_cyc();
    drive(2'b11, 5'd0, 1'b0, 10'h040, 1'b0, 5'd0, 10'h000);
    sb.push_back('{1'b1, 10'h000, "wrap_ret"});
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
      bad++;
      $display("FAIL %s: got jb_en=%b target=%h, want jb_en=%b target=%h",
               e.nm, jc.jb_en, jc.target, e.jb, e.tg);
    end
    next_cyc();
    drive(2'b10, 5'd2, 1'b0, 10'h100, 1'b0, 5'd0, 10'h000);
    next_cyc();
    drive(2'b10, 5'd2, 1'b0, 10'h200, 1'b0, 5'd0, 10'h000);
    next_cyc();
    drive(2'b00, 5'd0, 1'b0, 10'h000, 1'b0, 5'd0, 10'h000);
    @(negedge clk);
    total++;
    if ({jc.ras_empty, jc.fault} !== 2'b01) begin
      bad++;
      $display("FAIL pre_reset_status: got empty/fault=%b%b, want 01", jc.ras_empty, jc.fault);
    end
    next_cyc();
    // Reset must win over a same-cycle call and LUT write.
    reset = 1'b1;
    drive(2'b10, 5'd2, 1'b0, 10'h050, 1'b1, 5'd2, 10'h123);
    next_cyc();
    reset = 1'b0;
    drive(2'b00, 5'd0, 1'b0, 10'h000, 1'b0, 5'd0, 10'h000);
    @(negedge clk);
    total++;
    if ({jc.ras_empty, jc.ras_full, jc.fault} !== 3'b100) begin
      bad++;
      $display("FAIL post_reset_status: got empty/full/fault=%b%b%b, want 100",
               jc.ras_empty, jc.ras_full, jc.fault);
    end
    next_cyc();
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, (i == 0) ? 5'd2 : 5'd3, 1'b1, 10'h000, 1'b0, 5'd0, 10'h000);
      sb.push_back('{1'b1, 10'h000, (i == 0) ? "lut2_cleared" : "lut3_cleared"});
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({jc.jb_en, jc.target} !== {e.jb, e.tg}) begin
        bad++;
        $display("FAIL %s: got jb_en=%b target=%h, want jb_en=%b target=%h",
                 e.nm, jc.jb_en, jc.target, e.jb, e.tg);
      end
      next_cyc();
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_stack_limits();
    test_read_before_write();
    test_wrap_and_reset();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jump_ctrl.md
Name: jump_ctrl

Overview:
- Control-flow engine that drives the program counter's jump inputs (jb_en, target) from decoded branch/call/return ops.
- Holds a programmable absolute-target lookup table (LUT), a return-address stack (RAS) and a sticky fault flag.
- Sits between the instruction decoder and the PC. Its jb_en/target feed the PC's jump-enable/target inputs in the same cycle.

Parameters:
- D, 10, program-counter / address width.
- LW, 5, LUT index width; LUT holds 2**LW entries of D bits.
- SD, 4, RAS depth (entries); must be a power of 2, at least 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- prog_ctr  input  D  current PC value
- op  input  2  00 none, 01 branch-if-zero, 10 call, 11 return
- lut_idx  input  LW  LUT index used by branch/call
- zero_flag  input  1  ALU zero flag
- lut_we  input  1  LUT write enable
- lut_waddr  input  LW  LUT write index
- lut_wdata  input  D  LUT write data
- jb_en  output  1  jump enable to PC (combinational)
- target  output  D  jump target to PC (combinational)
- ras_empty  output  1  RAS holds 0 entries
- ras_full  output  1  RAS holds SD entries
- fault  output  1  sticky: RAS overflow or underflow occurred

Behaviour:
- Reset: clk and reset are already decided — reset is synchronous, active-high; clock is clk.
  - On reset, all LUT entries go to 0, the RAS pointer goes to 0 and fault goes to 0.
  - After reset: ras_empty=1, ras_full=0. jb_en=0 whenever op=00.
  - Reset has priority over every other input, including a call/return or LUT write in the same cycle.
- Outputs jb_en/target are combinational from op, lut_idx, zero_flag, the LUT and the RAS top, so the PC sees the redirect at the same edge.
- target=0 whenever jb_en=0.
- op=00: jb_en=0. No state change.
- op=01 (branch-if-zero): jb_en=zero_flag, target=LUT[lut_idx]. No state change.
- op=10 (call):
  - If not full: jb_en=1, target=LUT[lut_idx]. At the clock edge, push prog_ctr+1 (D-bit wrap, so all-ones+1 becomes 0) and increment the pointer.
  - If full: jb_en=0, nothing is pushed, and fault is set to 1 at the edge.
- op=11 (return):
  - If not empty: jb_en=1, target=RAS top entry. At the edge, pop by decrementing the pointer.
  - If empty: jb_en=0, target=0, and fault is set to 1 at the edge.
- Fault is sticky until reset. Operation continues normally while fault=1.
- RAS occupancy pointer has width clog2(SD)+1, range 0..SD.
  - ras_full is asserted at pointer=SD, ras_empty at pointer=0.
  - Entries above the pointer are don't-care.
- LUT write: when lut_we=1, LUT[lut_waddr] is updated at the edge.
  - Reads in the same cycle return the old value (read-before-write), including when lut_waddr equals lut_idx.
  - Writes are independent of op. A write and a call/branch may occur in the same cycle.
- Call targets use the LUT value as it stands before any same-cycle write.
- Back-to-back call/return on consecutive cycles is fully supported with no bubbles.

Test Plan:
- Reset, then op=00 for 3 cycles -> jb_en=0, target=0, ras_empty=1, ras_full=0, fault=0.
- Write LUT[3]=0x155. Next cycle op=01, lut_idx=3: with zero_flag=1 -> jb_en=1, target=0x155; with zero_flag=0 -> jb_en=0, target=0.
- LUT[2]=0x040. Call at prog_ctr=0x010 -> jb_en=1, target=0x040. Then return at prog_ctr=0x045 -> jb_en=1, target=0x011, and ras_empty=1 afterwards.
- Four calls at PCs 0x001..0x004 -> ras_full=1. A fifth call -> jb_en=0, fault=1, stack unchanged. Four returns -> targets 0x005, 0x004, 0x003, 0x002. A fifth return -> jb_en=0, fault stays 1.
- Same-cycle lut_we=1, lut_waddr=7, lut_wdata=0x2AA with op=01, lut_idx=7, zero_flag=1 -> target is the old LUT[7]. Next cycle the same branch -> target=0x2AA.
- Call at prog_ctr=0x3FF -> pushes 0x000; later return -> target=0x000. Assert reset with 2 entries on the RAS and fault=1 -> next cycle ras_empty=1, fault=0, LUT[2]=0.
